// File: rtl/bus_if6809_if.sv
`default_nettype none
// ============================================================================
// Interface : bus_if6809_if
// Purpose   : core request/ack bundle plus byte-wide memory bus for bus_if6809.
//             BUS_HALT_EN adds halt_b/ba.
// Revision  : 1.0
// ============================================================================
interface bus_if6809_if;
  logic        req;
  logic        req_we;
  logic        req_word;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        ack;
  logic        err;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic        mem_rw_n;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
`ifdef BUS_HALT_EN
  logic        halt_b;
  logic        ba;

  // Bus unit view: serves the core, masters the memory.
  modport slave (
    input  req, req_we, req_word, req_addr, req_wdata, mem_rdata, mem_ready, halt_b,
    output ack, err, rdata, busy, mem_addr, mem_valid, mem_rw_n, mem_wdata, ba
  );
  modport master (
    output req, req_we, req_word, req_addr, req_wdata, mem_rdata, mem_ready, halt_b,
    input  ack, err, rdata, busy, mem_addr, mem_valid, mem_rw_n, mem_wdata, ba
  );
`else
  // Bus unit view: serves the core, masters the memory.
  modport slave (
    input  req, req_we, req_word, req_addr, req_wdata, mem_rdata, mem_ready,
    output ack, err, rdata, busy, mem_addr, mem_valid, mem_rw_n, mem_wdata
  );
  modport master (
    output req, req_we, req_word, req_addr, req_wdata, mem_rdata, mem_ready,
    input  ack, err, rdata, busy, mem_addr, mem_valid, mem_rw_n, mem_wdata
  );
`endif
endinterface
`default_nettype wire

// File: rtl/bus_if6809.sv
`default_nettype none
// ============================================================================
// Module   : bus_if6809
// Purpose  : core6809 bus unit; 8/16-bit requests as big-endian byte cycles with
//            wait states and timeout. Optional halt/ba via BUS_HALT_EN.
// Revision : 1.0
// ============================================================================
module bus_if6809 #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  bus_if6809_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);
  localparam bit              c_to_en   = (TIMEOUT != 0);

  state_t           r_state,     w_state;
  logic             r_we,        w_we;
  logic             r_word,      w_word;
  logic [7:0]       r_wdata_lo,  w_wdata_lo;
  logic [TO_W-1:0]  r_cnt,       w_cnt;
  logic             r_ack,       w_ack;
  logic             r_err,       w_err;
  logic [15:0]      r_rdata,     w_rdata;
  logic             r_busy,      w_busy;
  logic [15:0]      r_mem_addr,  w_mem_addr;
  logic             r_mem_valid, w_mem_valid;
  logic             r_mem_rw_n,  w_mem_rw_n;
  logic [7:0]       r_mem_wdata, w_mem_wdata;
  logic [TO_W-1:0]  w_cnt_inc;
  logic             w_timeout;
  logic             w_accept_ok;

`ifdef BUS_HALT_EN
  logic r_ba;

  assign w_accept_ok = bus.halt_b;

  // Bus is only granted while idle; an in-flight transaction finishes first.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_ba <= 1'b0;
    else          r_ba <= (r_state == S_IDLE) && !bus.halt_b;
  end

  assign bus.ba = r_ba;
`else
  assign w_accept_ok = 1'b1;
`endif

  // The wait that would bring the count to TIMEOUT is the one that aborts.
  assign w_cnt_inc = r_cnt + TO_W'(1);
  assign w_timeout = c_to_en && (w_cnt_inc == c_timeout);

  always_comb begin
    w_state     = r_state;
    w_we        = r_we;
    w_word      = r_word;
    w_wdata_lo  = r_wdata_lo;
    w_cnt       = r_cnt;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_rdata     = r_rdata;
    w_mem_addr  = r_mem_addr;
    w_mem_valid = r_mem_valid;
    w_mem_rw_n  = r_mem_rw_n;
    w_mem_wdata = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (bus.req && w_accept_ok) begin
          w_state     = S_HI;
          w_we        = bus.req_we;
          w_word      = bus.req_word;
          w_wdata_lo  = bus.req_wdata[7:0];
          w_cnt       = '0;
          w_mem_valid = 1'b1;
          w_mem_addr  = bus.req_addr;
          w_mem_rw_n  = ~bus.req_we;
          w_mem_wdata = bus.req_word ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
        end
      end
      S_HI: begin
        if (bus.mem_ready) begin
          if (!r_we) w_rdata = r_word ? {bus.mem_rdata, r_rdata[7:0]} : {8'h00, bus.mem_rdata};
          if (r_word) begin
            w_state     = S_LO;
            w_cnt       = '0;
            w_mem_addr  = r_mem_addr + 16'd1;
            w_mem_wdata = r_wdata_lo;
          end else begin
            w_state     = S_ACK;
            w_ack       = 1'b1;
            w_mem_valid = 1'b0;
          end
        end else if (w_timeout) begin
          // Aborted word skips LO; both bytes read back as FF.
          if (!r_we) w_rdata = r_word ? 16'hFFFF : 16'h00FF;
          w_state     = S_ACK;
          w_ack       = 1'b1;
          w_err       = 1'b1;
          w_mem_valid = 1'b0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      S_LO: begin
        if (bus.mem_ready) begin
          if (!r_we) w_rdata = {r_rdata[15:8], bus.mem_rdata};
          w_state     = S_ACK;
          w_ack       = 1'b1;
          w_mem_valid = 1'b0;
        end else if (w_timeout) begin
          if (!r_we) w_rdata = {r_rdata[15:8], 8'hFF};
          w_state     = S_ACK;
          w_ack       = 1'b1;
          w_err       = 1'b1;
          w_mem_valid = 1'b0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      S_ACK: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state     = S_IDLE;
        w_mem_valid = 1'b0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_word      <= 1'b0;
      r_wdata_lo  <= 8'h00;
      r_cnt       <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 16'h0000;
      r_busy      <= 1'b0;
      r_mem_addr  <= 16'hFFFF;
      r_mem_valid <= 1'b0;
      r_mem_rw_n  <= 1'b1;
      r_mem_wdata <= 8'h00;
    end else begin
      r_state     <= w_state;
      r_we        <= w_we;
      r_word      <= w_word;
      r_wdata_lo  <= w_wdata_lo;
      r_cnt       <= w_cnt;
      r_ack       <= w_ack;
      r_err       <= w_err;
      r_rdata     <= w_rdata;
      r_busy      <= w_busy;
      r_mem_addr  <= w_mem_addr;
      r_mem_valid <= w_mem_valid;
      r_mem_rw_n  <= w_mem_rw_n;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_rw_n  = r_mem_rw_n;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_if6809.sv
`default_nettype none
// Testbench for bus_if6809: transaction table driven through ack and bus-cycle
// scoreboards, plus hand sequences for reset-in-flight and (optionally) halt.
module tb_bus_if6809;
  localparam int TIMEOUT = 15;
  localparam int TO_W    = 4;
  localparam int NVEC    = 8;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  bus_if6809_if bif ();

  bus_if6809 #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bif)
  );

  typedef struct {
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits_hi;
    int          waits_lo;
    logic [7:0]  byte_hi;
    logic [7:0]  byte_lo;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } ack_t;

  typedef struct {
    logic        rw_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cyc_t;

  ack_t ack_q[$];
  cyc_t cyc_q[$];
  vec_t vecs[NVEC];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},       32'(bif.ack),       32'h0);
    check({tag, "_err"},       32'(bif.err),       32'h0);
    check({tag, "_rdata"},     32'(bif.rdata),     32'h0);
    check({tag, "_busy"},      32'(bif.busy),      32'h0);
    check({tag, "_mem_valid"}, 32'(bif.mem_valid), 32'h0);
    check({tag, "_mem_rw_n"},  32'(bif.mem_rw_n),  32'h1);
    check({tag, "_mem_addr"},  32'(bif.mem_addr),  32'hFFFF);
    check({tag, "_mem_wdata"}, 32'(bif.mem_wdata), 32'h0);
  endtask

  // Drives one transaction and plays the memory; compares when the DUT responds.
  task automatic run_txn(input vec_t v, input string tag);
    ack_t a;
    cyc_t c;
    int   cyc;
    int   wctr;
    int   nbyte;
    int   nvalid;
    bit   done;
    int   nb;
    nb = v.word ? 2 : 1;
    for (int i = 0; i < nb; i++) begin
      int w;
      w = (i == 0) ? v.waits_hi : v.waits_lo;
      if (w >= TIMEOUT) break;
      c.rw_n  = ~v.we;
      c.addr  = v.addr + 16'(i);
      c.wdata = (v.word && i == 0) ? v.wdata[15:8] : v.wdata[7:0];
      cyc_q.push_back(c);
    end
    a.rdata = v.exp_rdata;
    a.err   = v.exp_err;
    a.lat   = v.exp_lat;
    ack_q.push_back(a);

    @(negedge clk);
    bif.req       = 1'b1;
    bif.req_we    = v.we;
    bif.req_word  = v.word;
    bif.req_addr  = v.addr;
    bif.req_wdata = v.wdata;
    bif.mem_ready = 1'b0;
    cyc = 0; wctr = 0; nbyte = 0; nvalid = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // Request fields are latched at the accept edge; later changes must not leak in.
        bif.req_we    = ~v.we;
        bif.req_word  = ~v.word;
        bif.req_addr  = ~v.addr;
        bif.req_wdata = ~v.wdata;
      end
      bif.mem_ready = 1'b0;
      bif.mem_rdata = 8'($urandom);
      if (bif.ack) begin
        bif.req = 1'b0;
        done    = 1'b1;
        check({tag, "_ack_expected"}, 32'(ack_q.size()), 32'd1);
        if (ack_q.size() > 0) begin
          a = ack_q.pop_front();
          check({tag, "_rdata"},   32'(bif.rdata), 32'(a.rdata));
          check({tag, "_err"},     32'(bif.err),   32'(a.err));
          check({tag, "_latency"}, cyc,            a.lat);
          check({tag, "_busy"},    32'(bif.busy),  32'h1);
        end
        check({tag, "_valid_cycles"}, nvalid, v.exp_lat - 1);
      end else if (bif.mem_valid) begin
        nvalid++;
        if (wctr >= ((nbyte == 0) ? v.waits_hi : v.waits_lo)) begin
          bif.mem_ready = 1'b1;
          bif.mem_rdata = (nbyte == 0) ? v.byte_hi : v.byte_lo;
          check({tag, "_cycle_expected"}, 32'(cyc_q.size() > 0), 32'h1);
          if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            check({tag, "_mem_addr"}, 32'(bif.mem_addr), 32'(c.addr));
            check({tag, "_mem_rw_n"}, 32'(bif.mem_rw_n), 32'(c.rw_n));
            if (!c.rw_n) check({tag, "_mem_wdata"}, 32'(bif.mem_wdata), 32'(c.wdata));
          end
          nbyte++;
          wctr = 0;
        end else begin
          wctr++;
        end
      end
    end
    check({tag, "_ack_seen"}, 32'(done), 32'h1);
    check({tag, "_cycles_left"}, 32'(cyc_q.size()), 32'h0);
    bif.req = 1'b0;
    bif.mem_ready = 1'b0;
    ack_q.delete();
    cyc_q.delete();
    @(negedge clk);
    check({tag, "_ack_pulse"}, 32'(bif.ack),  32'h0);
    check({tag, "_idle_busy"}, 32'(bif.busy), 32'h0);
  endtask

  initial begin
    int acks;
    vec_t r;
    //           we    word  addr     wdata    whi wlo hi     lo     rdata    err   lat
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 0,  0, 8'hA5, 8'h00, 16'h00A5, 1'b0, 2};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 0,  0, 8'h12, 8'h34, 16'h1234, 1'b0, 3};
    vecs[2] = '{1'b1, 1'b1, 16'h2000, 16'hBEEF, 2,  2, 8'h00, 8'h00, 16'h1234, 1'b0, 7};
    vecs[3] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 99, 0, 8'h00, 8'h00, 16'h00FF, 1'b1, 16};
    vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'h775A, 1,  0, 8'h00, 8'h00, 16'h00FF, 1'b0, 3};
    vecs[5] = '{1'b0, 1'b1, 16'h5000, 16'h0000, 14, 14, 8'hC3, 8'h3C, 16'hC33C, 1'b0, 31};
    vecs[6] = '{1'b0, 1'b1, 16'h6000, 16'h0000, 99, 0, 8'h00, 8'h00, 16'hFFFF, 1'b1, 16};
    vecs[7] = '{1'b0, 1'b1, 16'h7000, 16'h0000, 0,  99, 8'h77, 8'h00, 16'h77FF, 1'b1, 17};

    reset_b       = 1'b0;
    bif.req       = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_word  = 1'b0;
    bif.req_addr  = 16'h0000;
    bif.req_wdata = 16'h0000;
    bif.mem_rdata = 8'h00;
    bif.mem_ready = 1'b1;
`ifdef BUS_HALT_EN
    bif.halt_b    = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_b = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    for (int i = 0; i < NVEC; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while the LO byte of a word read is waiting.
    @(negedge clk);
    bif.req = 1'b1; bif.req_we = 1'b0; bif.req_word = 1'b1; bif.req_addr = 16'h4000;
    @(negedge clk);
    bif.mem_ready = 1'b1; bif.mem_rdata = 8'h11;
    @(negedge clk);
    bif.mem_ready = 1'b0;
    check("rst_lo_addr", 32'(bif.mem_addr), 32'h4001);
    reset_b = 1'b0;
    bif.req = 1'b0;
    #1;
    check_reset_values("rst_inflight");
    @(negedge clk);
    reset_b = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bif.ack) acks++;
    end
    check("rst_no_ack", acks, 0);
    check("rst_idle_valid", 32'(bif.mem_valid), 32'h0);
    r = '{1'b0, 1'b0, 16'h4000, 16'h0000, 0, 0, 8'h5C, 8'h00, 16'h005C, 1'b0, 2};
    run_txn(r, "after_rst");

`ifdef BUS_HALT_EN
    // Halted: request must not be accepted and the bus is granted.
    @(negedge clk);
    bif.halt_b = 1'b0;
    bif.req = 1'b1; bif.req_we = 1'b0; bif.req_word = 1'b0; bif.req_addr = 16'h0100;
    repeat (3) @(negedge clk);
    check("halt_valid", 32'(bif.mem_valid), 32'h0);
    check("halt_busy",  32'(bif.busy),      32'h0);
    check("halt_ba",    32'(bif.ba),        32'h1);
    bif.halt_b = 1'b1;
    r = '{1'b0, 1'b0, 16'h0100, 16'h0000, 0, 0, 8'h3E, 8'h00, 16'h003E, 1'b0, 2};
    run_txn(r, "after_halt");
    check("unhalt_ba", 32'(bif.ba), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
